// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared SPI definitions: command codes, frame sizes, the
//                controller state encoding and a small command decode helper.
//                Used by the SPI master controller and the slave-side blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

  // Command codes carried in the two MSBs of every frame
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Frame geometry: 2 command bits followed by an 8-bit payload
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  // Terminal values of the shared 4-bit bit counter
  localparam logic [3:0] SEND_LAST = 4'd9;
  localparam logic [3:0] READ_LAST = 4'd7;

  // Controller state encoding
  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_SEND = 3'd1;
  localparam state_t ST_WAIT = 3'd2;
  localparam state_t ST_READ = 3'd3;
  localparam state_t ST_END  = 3'd4;

  // Only the read-data command has a turnaround and a receive phase
  function automatic logic is_rd_data(input logic [1:0] c);
    return (c == CMD_RD_DATA);
  endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_ctrl
//  Description : SPI master transaction controller. On start it shifts out a
//                10-bit {cmd, wdata} frame MSB-first. Read-data commands then
//                wait RD_LATENCY turnaround cycles and shift in one byte from
//                MISO, MSB-first, which is presented on rdata.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk    in   system clock, rising edge
//    rst_n  in   asynchronous active-low reset
//    start  in   transaction request, only looked at while idle
//    cmd    in   [1:0] command code (see spi_pkg)
//    wdata  in   [7:0] payload sent after cmd
//    MISO   in   serial data from slave
//    SS_n   out  slave select, active-low
//    MOSI   out  serial data to slave
//    busy   out  high while a transaction is in progress
//    done   out  one-cycle pulse in the final cycle of a transaction
//    rdata  out  [7:0] byte captured by the last read-data transaction
// ============================================================================
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  input  logic       MISO,
  output logic       SS_n,
  output logic       MOSI,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata
);

  localparam logic [3:0] WAIT_LAST = 4'(RD_LATENCY - 1);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q,   cnt_d;
  logic [FRAME_BITS-1:0]   tx_q,    tx_d;
  logic [DATA_BITS-1:0]    rx_q,    rx_d;
  logic [DATA_BITS-1:0]    rdata_q, rdata_d;
  // The command bits are shifted out of tx_q, so the read/write decision
  // taken at the end of SEND needs its own copy.
  logic                    rd_q,    rd_d;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SEND;
      ST_SEND: if (cnt_q == SEND_LAST) state_d = rd_q ? ST_WAIT : ST_END;
      ST_WAIT: if (cnt_q == WAIT_LAST) state_d = ST_READ;
      ST_READ: if (cnt_q == READ_LAST) state_d = ST_END;
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from the current state only)
  // --------------------------------------------------------------------------
  always_comb begin
    SS_n = 1'b1;
    MOSI = 1'b0;
    busy = 1'b1;
    done = 1'b0;
    case (state_q)
      ST_IDLE: busy = 1'b0;
      ST_SEND: begin
        SS_n = 1'b0;
        MOSI = tx_q[FRAME_BITS-1];
      end
      ST_WAIT,
      ST_READ: SS_n = 1'b0;
      ST_END:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign rdata = rdata_q;

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d   = '0;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;

    case (state_q)
      ST_IDLE: begin
        // Frame is captured here so later cmd/wdata changes cannot leak in
        if (start) begin
          tx_d = {cmd, wdata};
          rd_d = is_rd_data(cmd);
        end
      end
      ST_SEND: tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
      ST_READ: begin
        rx_d = {rx_q[DATA_BITS-2:0], MISO};
        // Publish the completed byte together with the move into END
        if (state_d == ST_END) rdata_d = rx_d;
      end
      default: ;
    endcase

    // Counter restarts from zero on every state change and only advances
    // while the state holds, so it never passes a terminal count.
    if ((state_d == state_q) &&
        ((state_q == ST_SEND) || (state_q == ST_WAIT) || (state_q == ST_READ))) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
    end
  end

endmodule : spi_master_ctrl
`default_nettype wire
